// File: rtl/mdc8p_ctrl_out.sv
// Output controller for a radix-2 MDC FFT stage: reorders bit-reversed lane pairs
// into natural order through a ping-pong buffer and streams them out over AXI-Stream.
module mdc8p_ctrl_out #(
    parameter int NB = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NB-1:0]   i_data0_r,
    input  logic [NB-1:0]   i_data0_i,
    input  logic [NB-1:0]   i_data1_r,
    input  logic [NB-1:0]   i_data1_i,
    input  logic            i_valid,
    output logic            m_axis_data_tvalid,
    output logic [2*NB-1:0] m_axis_data_tdata,
    output logic            m_axis_data_tlast,
    input  logic            m_axis_data_tready,
    output logic            o_overflow
);

    localparam int DW = 2 * NB;

    // Two 8-entry banks flattened into one array; address = {bank, sample index}.
    logic [DW-1:0] mem [16];

    logic [1:0] wr_cnt;
    logic       wr_sel;
    logic       wr_drop;
    logic [1:0] full;
    logic       rd_sel;
    logic [2:0] idx;
    logic       overflow_q;

    logic       accept;
    logic       wr_en;
    logic       rd_fire;
    logic [2:0] wr_pair;

    // Input cycle k carries the pair starting at natural index bitrev2(k)*2.
    assign wr_pair = {wr_sel, wr_cnt[0], wr_cnt[1]};

    // The bank decision is taken on the first beat and remembered for the rest of the frame.
    assign accept  = (wr_cnt == 2'd0) ? !full[wr_sel] : !wr_drop;
    assign wr_en   = i_valid && accept;
    assign rd_fire = full[rd_sel] && m_axis_data_tready;

    // NOTE: the sample store has no reset; stale contents are harmless because
    // the full flags gate every read, and a reset-free array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[{wr_pair, 1'b0}] <= {i_data0_r, i_data0_i};
            mem[{wr_pair, 1'b1}] <= {i_data1_r, i_data1_i};
        end
    end

    // NOTE: all state uses non-blocking assignments, so the writer and the reader
    // both see pre-edge flags even when they touch different bits of full on one edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_cnt     <= 2'd0;
            wr_sel     <= 1'b0;
            wr_drop    <= 1'b0;
            full       <= 2'b00;
            rd_sel     <= 1'b0;
            idx        <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;

            if (i_valid) begin
                wr_cnt <= wr_cnt + 2'd1;
                if (wr_cnt == 2'd0) begin
                    wr_drop <= full[wr_sel];
                end
                if (wr_cnt == 2'd3) begin
                    if (accept) begin
                        full[wr_sel] <= 1'b1;
                        wr_sel       <= ~wr_sel;
                    end else begin
                        overflow_q   <= 1'b1;
                    end
                end
            end

            // The writer only ever fills an empty bank and the reader only drains a full one,
            // so the two updates to full never land on the same bit.
            if (rd_fire) begin
                if (idx == 3'd7) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    idx          <= 3'd0;
                end else begin
                    idx          <= idx + 3'd1;
                end
            end
        end
    end

    assign m_axis_data_tvalid = full[rd_sel];
    assign m_axis_data_tdata  = full[rd_sel] ? mem[{rd_sel, idx}] : '0;
    assign m_axis_data_tlast  = full[rd_sel] && (idx == 3'd7);
    assign o_overflow         = overflow_q;

endmodule

// File: tb/tb_mdc8p_ctrl_out.sv
// Randomised bench for mdc8p_ctrl_out: a frame-queue reference model predicts
// every output each cycle; directed phases cover the listed scenarios.
module tb_mdc8p_ctrl_out;

    localparam int NB = 8;
    localparam int DW = 2 * NB;

    typedef logic [7:0][DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] d0r, d0i, d1r, d1i;
    logic          valid;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready;
    logic          overflow;

    always #5 clk = ~clk;

    mdc8p_ctrl_out #(.NB(NB)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_data0_r          (d0r),
        .i_data0_i          (d0i),
        .i_data1_r          (d1r),
        .i_data1_i          (d1i),
        .i_valid            (valid),
        .m_axis_data_tvalid (tvalid),
        .m_axis_data_tdata  (tdata),
        .m_axis_data_tlast  (tlast),
        .m_axis_data_tready (tready),
        .o_overflow         (overflow)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ovf_seen = 0;
    int last_seen = 0;

    // Reference model: complete frames waiting or being output, in arrival order.
    frame_t q[$];
    frame_t cur;
    int     beat = 0;
    int     k = 0;
    bit     cur_drop = 1'b0;
    bit     exp_ovf = 1'b0;
    int     slot[4] = '{0, 4, 2, 6};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        int n;
        bit hs;
        if (!rst_n) begin
            q.delete();
            beat     = 0;
            k        = 0;
            cur_drop = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            n       = q.size();
            hs      = (n > 0) && tready;
            exp_ovf = 1'b0;
            if (hs) begin
                if (beat == 7) begin
                    void'(q.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (valid) begin
                if (k == 0) cur_drop = (n >= 2);
                cur[slot[k]]     = {d0r, d0i};
                cur[slot[k] + 1] = {d1r, d1i};
                if (k == 3) begin
                    if (cur_drop) exp_ovf = 1'b1;
                    else          q.push_back(cur);
                end
                k = (k + 1) % 4;
            end
        end
    endtask

    function automatic bit ready_of(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (cyc % 2) == 0;
            default: return $urandom_range(0, 99) < 60;
        endcase
    endfunction

    // Drive one cycle, advance the model across the edge, then compare at the falling edge.
    task automatic cycle(input bit rst, input bit v, input logic [DW-1:0] s0,
                         input logic [DW-1:0] s1, input bit rdy);
        logic [DW-1:0] exp_data;
        rst_n  = rst;
        valid  = v;
        {d0r, d0i} = s0;
        {d1r, d1i} = s1;
        tready = rdy;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        exp_data = (q.size() > 0) ? q[0][beat] : '0;
        check("tvalid",   {31'd0, tvalid},   {31'd0, q.size() > 0});
        check("tdata",    {16'd0, tdata},    {16'd0, exp_data});
        check("tlast",    {31'd0, tlast},    {31'd0, (q.size() > 0) && (beat == 7)});
        check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (overflow) ovf_seen++;
        if (tvalid && tlast && tready) last_seen++;
    endtask

    // gaps[2*kk +: 2] idle cycles precede input cycle kk; seq=1 uses value n at natural index n.
    task automatic send_frame(input bit seq, input logic [7:0] gaps, input int rmode);
        frame_t nat;
        for (int n = 0; n < 8; n++) begin
            nat[n] = seq ? {NB'(n), NB'(n)} : DW'($urandom);
        end
        for (int kk = 0; kk < 4; kk++) begin
            for (int g = 0; g < int'(gaps[2*kk +: 2]); g++) begin
                cycle(1'b1, 1'b0, DW'($urandom), DW'($urandom), ready_of(rmode));
            end
            cycle(1'b1, 1'b1, nat[slot[kk]], nat[slot[kk] + 1], ready_of(rmode));
        end
    endtask

    task automatic drain(input int rmode);
        int n = 0;
        while (q.size() > 0 && n < 400) begin
            cycle(1'b1, 1'b0, '0, '0, ready_of(rmode));
            n++;
        end
        check("drain_done", {31'd0, n < 400}, 32'd1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int ovf_base;
        int last_base;

        // Reset state
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b1, 16'hffff, 16'hffff, 1'b1);

        // Single frame, tready held high
        last_base = last_seen;
        send_frame(1'b1, 8'h00, 1);
        drain(1);
        check("single_frame_tlasts", last_seen - last_base, 32'd1);

        // Backpressure with tready toggling
        send_frame(1'b1, 8'h00, 2);
        drain(2);

        // Back-to-back frames with no bubble
        last_base = last_seen;
        send_frame(1'b0, 8'h00, 1);
        send_frame(1'b0, 8'h00, 1);
        drain(1);
        check("b2b_tlasts", last_seen - last_base, 32'd2);

        // Overflow: three frames with the reader stalled
        ovf_base = ovf_seen;
        send_frame(1'b0, 8'h00, 0);
        send_frame(1'b0, 8'h00, 0);
        send_frame(1'b0, 8'h00, 0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        check("overflow_pulses", ovf_seen - ovf_base, 32'd1);
        last_base = last_seen;
        drain(1);
        check("overflow_tlasts", last_seen - last_base, 32'd2);

        // Gapped input: valid pattern 1,0,0,1,1,0,1
        send_frame(1'b1, 8'b01_00_10_00, 1);
        drain(1);

        // Reset mid-output after three beats
        send_frame(1'b0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        send_frame(1'b0, 8'h00, 1);
        drain(1);

        // Randomised traffic with random gaps and random backpressure
        for (int f = 0; f < 40; f++) begin
            send_frame(1'b0, 8'($urandom), 3);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
                    cycle(1'b1, 1'b0, '0, '0, ready_of(3));
                end
            end
        end
        drain(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdc8p_ctrl_out.md
MDC8P_CTRL_OUT -- requirements
Module: mdc8p_ctrl_out

Interface
REQ-001 SHALL have parameter NB, default 8, the bit width of each real or imaginary component.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have ports i_data0_r and i_data0_i, inputs, NB bits each: lane-0 sample, real and imaginary.
REQ-005 SHALL have ports i_data1_r and i_data1_i, inputs, NB bits each: lane-1 sample, real and imaginary.
REQ-006 SHALL have port i_valid, input, 1 bit: both lanes carry a valid sample this cycle.
REQ-007 SHALL have port m_axis_data_tvalid, output, 1 bit: AXIS master valid.
REQ-008 SHALL have port m_axis_data_tdata, output, 2*NB bits: {real, imag}, with real in the upper NB bits.
REQ-009 SHALL have port m_axis_data_tlast, output, 1 bit: marks the last sample of a frame.
REQ-010 SHALL have port m_axis_data_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have port o_overflow, output, 1 bit: one-cycle pulse when an input frame is dropped.

Function
REQ-012 SHALL treat one frame as 4 i_valid cycles (8 samples); i_valid cycles need not be contiguous, and the input write counter (0..3) holds while i_valid is low.
REQ-013 SHALL map input cycle k (0..3) as follows: lane 0 carries X[bitrev2(k)*2], lane 1 carries X[bitrev2(k)*2+1].
- This gives k=0 -> X0,X1; k=1 -> X4,X5; k=2 -> X2,X3; k=3 -> X6,X7.
- Each sample SHALL be stored at its natural index.
REQ-014 SHALL contain two 8-entry banks (ping-pong), each holding an empty/full flag; the writer and the reader each hold a bank select.
REQ-015 SHALL, on the first i_valid of a frame (counter=0), write the frame into the write bank if that bank is empty; otherwise the entire frame SHALL be discarded.
REQ-016 SHALL, on the edge capturing the 4th sample of an accepted frame, set that bank full and toggle the write bank select.
REQ-017 SHALL, for a discarded frame, still advance the write counter, leave both banks unchanged, and pulse o_overflow high for exactly the cycle after the edge that captures its 4th valid.
REQ-018 SHALL, while the read bank is full, assert tvalid and drive tdata = bank[read][idx] and tlast = (idx==7), with idx starting at 0.
REQ-019 SHALL advance idx only on tvalid && tready; on a handshake with idx==7 it SHALL mark the read bank empty, reset idx to 0, and toggle the read bank select.
REQ-020 SHALL hold tdata, tlast and tvalid stable while tvalid && !tready.
REQ-021 SHALL assert tvalid in the first cycle after the edge that sets a bank full, when the reader is idle (latency 1 cycle from the last capture).
REQ-022 SHALL, when the reader empties one bank on the same edge the other bank becomes full, continue with the next frame in the very next cycle with no bubble.
REQ-023 SHALL allow a bank emptied on edge E to accept a frame whose first valid arrives on edge E+1 or later.
- A first valid on edge E itself sees the bank as full and SHALL be discarded.
REQ-024 SHALL drive tvalid low and tdata to 0 while no bank is full.

Reset
REQ-025 SHALL, while i_rst_n=0 at a rising edge, clear the following, discarding any partial or buffered frame:
- tvalid, tlast, tdata and o_overflow to 0;
- both bank flags to empty;
- both bank selects to bank 0;
- the write counter and idx to 0.
REQ-026 SHALL produce first output one cycle after reset release at the earliest, after a full frame has been captured.

Verification
REQ-027 Single frame, tready=1: inputs (k: d0,d1) = (0:0,1)(1:4,5)(2:2,3)(3:6,7), with real=imag=value -> tdata 0x0000,0x0101,...,0x0707 on 8 consecutive cycles; tlast only on 0x0707; tvalid rises the cycle after the 4th capture.
REQ-028 Backpressure: same frame with tready toggling 1,0,1,0,... -> each sample held stable until accepted; 8 handshakes, order 0..7.
REQ-029 Back-to-back frames A then B, tready=1 -> 16 contiguous output beats A0..A7 then B0..B7; tlast on beats 8 and 16; no bubble between frames.
REQ-030 Overflow: tready=0 and three frames sent -> frames 1 and 2 buffered; frame 3 dropped with o_overflow one-cycle pulse; after tready=1, only frames 1 and 2 are output.
REQ-031 Gapped input: i_valid pattern 1,0,0,1,1,0,1 -> output identical to the contiguous case.
REQ-032 Reset mid-output: i_rst_n=0 after beat 3 of a frame -> tvalid=0 and tdata=0 the next cycle; a new frame then outputs from index 0 with its own data.
